bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  MEM_AW, 12, RAM address width; RAM holds 2^MEM_AW bytes.
  MEM_WS, 1, wait states for memory cycles (0..15).
  IO_WS, 2, wait states for I/O cycles (0..15).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Reset arst is asynchronous and active-high; the clock is clk.
  clk  in  1  clock
  arst  in  1  asynchronous active-high reset
  addr  in  22  CPU address
  wdata  in  8  CPU write data (CPU data_out)
  rd  in  1  read strobe
  wr  in  1  write strobe
  mem_io  in  1  1 = memory space, 0 = I/O space
  dma_ack  in  1  CPU grants the bus
  rdata  out  8  read data to CPU data_in
  WAIT  out  1  stall request to CPU
  irq_out  out  8  interrupt lines to CPU irq_in
  dma_req  out  1  bus request to CPU

Function
REQ-003 All outputs SHALL be registered on the rising edge of clk.
REQ-004 The FSM SHALL have three states: IDLE, STALL and DONE.
REQ-005 Cycle start: in IDLE, a clk edge sampling rd|wr=1 SHALL latch addr, mem_io, wdata and direction; later changes to these inputs SHALL be ignored until the next IDLE.
REQ-006 The wait count N SHALL be MEM_WS when mem_io=1 and IO_WS when mem_io=0.
  - N>0: move to STALL; WAIT=1 for exactly N cycles, then DONE.
  - N=0: move straight to DONE; WAIT stays 0.
REQ-007 On entry to DONE, reads SHALL update rdata with the addressed byte.
  - rdata SHALL hold its value until the next read completes.
REQ-008 On entry to DONE, writes SHALL update the target exactly once.
REQ-009 DONE SHALL return to IDLE on the first edge sampling rd=0 and wr=0, giving a minimum of one idle cycle between transactions.
REQ-010 If rd and wr are both 1 at cycle start, the cycle SHALL be handled as a read, the write SHALL be suppressed, and ERR bit0 SHALL set (sticky).
REQ-011 Memory read, addr < 2^MEM_AW: the RAM byte SHALL be returned.
  - Otherwise: 0xFF SHALL be returned and writes SHALL be dropped.
REQ-012 The I/O map SHALL decode addr[7:0] only.
  - 0x00 SCRATCH: R/W.
  - 0x01 IRQ_SET: write ORs into irq_out; read returns irq_out.
  - 0x02 IRQ_CLR: write clears the bits that are set in wdata; read returns irq_out.
  - 0x03 DMA_CTRL: write bit0=1 starts DMA; read returns {7'b0, dma_busy}.
  - 0x04 DMA_LEN: R/W, hold length in cycles.
  - 0x05 ERR: read returns sticky bits; any write clears them.
  - All other addresses: read 0x00; writes ignored.
REQ-013 The DMA FSM SHALL have three states: D_IDLE, D_REQ and D_HOLD.
  - A DMA_CTRL start in D_IDLE SHALL go to D_REQ with dma_req=1.
  - In D_REQ, the first edge sampling dma_ack=1 SHALL go to D_HOLD, counter loaded with DMA_LEN.
  - D_HOLD SHALL decrement the counter each cycle; when it reaches 0, it SHALL set dma_req=0 and return to D_IDLE.
  - DMA_LEN=0 SHALL release dma_req on the first edge in D_HOLD.
  - dma_busy = (state != D_IDLE).
REQ-014 A DMA_CTRL start while dma_busy=1 SHALL be ignored and SHALL set ERR bit1.
REQ-015 A dma_ack=1 in D_IDLE SHALL be ignored.
REQ-016 The counter is 8 bits; DMA_LEN SHALL be reloaded only when entering D_HOLD.
  - A write to DMA_LEN during D_HOLD SHALL not alter the running count.
REQ-017 An IRQ_SET or IRQ_CLR write SHALL take effect on the edge that enters DONE.

Reset
REQ-018 While arst=1, outputs SHALL be: WAIT=0, rdata=0x00, irq_out=0x00, dma_req=0.
  - Both FSMs SHALL be IDLE / D_IDLE.
  - SCRATCH, DMA_LEN and ERR SHALL be 0x00.
REQ-019 RAM contents SHALL not be reset.
REQ-020 Reset asserted mid-transaction SHALL abort it with no write performed and WAIT deasserted immediately (asynchronously).
REQ-021 After reset release, the next rd|wr=1 edge SHALL start a fresh cycle.

Verification
REQ-022 Memory cycles, MEM_WS=1:
  - Stimulus: write 0x5A to mem 0x000123, then read it.
  - Response: each cycle shows WAIT=1 for exactly 1 cycle; rdata=0x5A in the cycle after WAIT falls.
REQ-023 I/O cycles with IO_WS=2, then MEM_WS=0:
  - Stimulus: I/O write 0x81 to 0x01, then 0x01 to 0x02; then a mem read at addr 0x3FFFFF.
  - Response: WAIT high 2 cycles per I/O cycle; irq_out=0x81 then 0x80; mem read returns 0xFF with no WAIT.
REQ-024 DMA:
  - Stimulus: write DMA_LEN=3, then DMA_CTRL=0x01; hold dma_ack=0 for 5 cycles, then 1.
  - Response: dma_req stays 1; it drops exactly 4 edges after the edge sampling dma_ack=1; DMA_CTRL then reads 0x00.
REQ-025 Mid-DMA restart: a second DMA_CTRL write while dma_req=1 SHALL leave the transfer unchanged, and ERR reads 0x02.
REQ-026 Simultaneous strobes: rd=wr=1 at mem 0x000010 holding 0x33 SHALL return 0x33, leave RAM unchanged, and ERR reads 0x01.
REQ-027 Reset mid-stall: arst pulsed during STALL of a write of 0x77 to mem 0x000020 (old value 0x11) SHALL drop WAIT immediately, and a later read SHALL return 0x11.

Source files
------------

// File: rtl/bus_responder.sv
// Bus-side responder for a simple CPU: wait-stated memory/I-O cycles, a small
// register file with interrupt and DMA-request control, and a byte RAM.
module bus_responder #(
    parameter int MEM_AW = 12,
    parameter int MEM_WS = 1,
    parameter int IO_WS  = 2
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [21:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rd,
    input  logic        wr,
    input  logic        mem_io,
    input  logic        dma_ack,
    output logic [7:0]  rdata,
    output logic        WAIT,
    output logic [7:0]  irq_out,
    output logic        dma_req
);
    localparam int MEM_BYTES = 1 << MEM_AW;

    typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, DONE = 2'd2} bus_state_t;
    typedef enum logic [1:0] {D_IDLE = 2'd0, D_REQ = 2'd1, D_HOLD = 2'd2} dma_state_t;

    logic [7:0]  mem_r [0:MEM_BYTES-1];
    bus_state_t  state_r, state_s;
    dma_state_t  dstate_r, dstate_s;
    logic [3:0]  wcnt_r, wcnt_s, n_s;
    logic        wait_s, latch_s, access_s, dreq_s;
    logic [21:0] addr_r, cur_addr_s;
    logic [7:0]  wdata_r, cur_wdata_s;
    logic        mem_io_r, is_rd_r, both_r;
    logic        cur_mem_io_s, cur_rd_s, cur_both_s;
    logic [7:0]  scratch_r, dma_len_r, dma_cnt_r, dma_cnt_s;
    logic [1:0]  err_r;
    logic [7:0]  io_val_s, rd_val_s;
    logic        in_range_s, mem_we_s, io_we_s, dma_start_s, dma_busy_s;

    // Current transaction: live inputs while idle, latched copy afterwards
    always_comb begin
        if (state_r == IDLE) begin
            cur_addr_s   = addr;
            cur_wdata_s  = wdata;
            cur_mem_io_s = mem_io;
            cur_rd_s     = rd;
            cur_both_s   = rd & wr;
        end else begin
            cur_addr_s   = addr_r;
            cur_wdata_s  = wdata_r;
            cur_mem_io_s = mem_io_r;
            cur_rd_s     = is_rd_r;
            cur_both_s   = both_r;
        end
    end

    assign n_s         = cur_mem_io_s ? 4'(MEM_WS) : 4'(IO_WS);
    assign in_range_s  = (cur_addr_s >> MEM_AW) == 22'd0;
    assign mem_we_s    = access_s & ~cur_rd_s & cur_mem_io_s & in_range_s & ~arst;
    assign io_we_s     = access_s & ~cur_rd_s & ~cur_mem_io_s;
    assign dma_start_s = io_we_s && (cur_addr_s[7:0] == 8'h03) && cur_wdata_s[0];
    assign dma_busy_s  = (dstate_r != D_IDLE);

    // I/O register read decode (low address byte only)
    always_comb begin
        case (cur_addr_s[7:0])
            8'h00:   io_val_s = scratch_r;
            8'h01:   io_val_s = irq_out;
            8'h02:   io_val_s = irq_out;
            8'h03:   io_val_s = {7'd0, dma_busy_s};
            8'h04:   io_val_s = dma_len_r;
            8'h05:   io_val_s = {6'd0, err_r};
            default: io_val_s = 8'h00;
        endcase
        if (cur_mem_io_s) begin
            rd_val_s = in_range_s ? mem_r[cur_addr_s[MEM_AW-1:0]] : 8'hFF;
        end else begin
            rd_val_s = io_val_s;
        end
    end

    // Bus FSM next state; access_s marks the edge that enters DONE
    always_comb begin
        state_s  = state_r;
        wcnt_s   = wcnt_r;
        wait_s   = 1'b0;
        latch_s  = 1'b0;
        access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rd | wr) begin
                    latch_s = 1'b1;
                    if (n_s == 4'd0) begin
                        state_s  = DONE;
                        access_s = 1'b1;
                    end else begin
                        state_s = STALL;
                        wait_s  = 1'b1;
                        wcnt_s  = n_s - 4'd1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            STALL: begin
                if (wcnt_r == 4'd0) begin
                    state_s  = DONE;
                    access_s = 1'b1;
                end else begin
                    wait_s = 1'b1;
                    wcnt_s = wcnt_r - 4'd1;
                end
            end
            DONE: begin
                if (!rd && !wr) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // DMA FSM next state; the hold count is loaded only on entry to D_HOLD
    always_comb begin
        dstate_s  = dstate_r;
        dma_cnt_s = dma_cnt_r;
        dreq_s    = dma_req;
        case (dstate_r)
            D_IDLE: begin
                if (dma_start_s) begin
                    dstate_s = D_REQ;
                    dreq_s   = 1'b1;
                end else begin
                    dstate_s = D_IDLE;
                end
            end
            D_REQ: begin
                if (dma_ack) begin
                    dstate_s  = D_HOLD;
                    dma_cnt_s = dma_len_r;
                end else begin
                    dstate_s = D_REQ;
                end
            end
            D_HOLD: begin
                if (dma_cnt_r == 8'd0) begin
                    dstate_s = D_IDLE;
                    dreq_s   = 1'b0;
                end else begin
                    dma_cnt_s = dma_cnt_r - 8'd1;
                end
            end
            default: begin
                dstate_s = D_IDLE;
                dreq_s   = 1'b0;
            end
        endcase
    end

    // State, outputs and register file
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r   <= IDLE;
            dstate_r  <= D_IDLE;
            wcnt_r    <= 4'd0;
            WAIT      <= 1'b0;
            rdata     <= 8'h00;
            irq_out   <= 8'h00;
            dma_req   <= 1'b0;
            dma_cnt_r <= 8'd0;
            addr_r    <= 22'd0;
            wdata_r   <= 8'h00;
            mem_io_r  <= 1'b0;
            is_rd_r   <= 1'b0;
            both_r    <= 1'b0;
            scratch_r <= 8'h00;
            dma_len_r <= 8'h00;
            err_r     <= 2'b00;
        end else begin
            state_r   <= state_s;
            dstate_r  <= dstate_s;
            wcnt_r    <= wcnt_s;
            WAIT      <= wait_s;
            dma_req   <= dreq_s;
            dma_cnt_r <= dma_cnt_s;
            if (latch_s) begin
                addr_r   <= addr;
                wdata_r  <= wdata;
                mem_io_r <= mem_io;
                is_rd_r  <= rd;
                both_r   <= rd & wr;
            end
            if (access_s && cur_rd_s) begin
                rdata <= rd_val_s;
            end
            if (access_s && cur_both_s) begin
                err_r[0] <= 1'b1;
            end
            if (io_we_s) begin
                case (cur_addr_s[7:0])
                    8'h00: scratch_r <= cur_wdata_s;
                    8'h01: irq_out   <= irq_out | cur_wdata_s;
                    8'h02: irq_out   <= irq_out & ~cur_wdata_s;
                    8'h03: if (cur_wdata_s[0] && dma_busy_s) err_r[1] <= 1'b1;
                    8'h04: dma_len_r <= cur_wdata_s;
                    8'h05: err_r     <= 2'b00;
                    default: ;
                endcase
            end
        end
    end

    // RAM: no reset; a write is dropped if reset is present at the edge
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[cur_addr_s[MEM_AW-1:0]] <= cur_wdata_s;
        end
    end
endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder against a transaction-level model of the
// register map, RAM, wait states and DMA hold timing.
module tb_bus_responder;
    localparam int MEM_AW = 12;
    localparam int MEM_WS = 1;
    localparam int IO_WS  = 2;
    localparam int MEM_BYTES = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [21:0] addr = 22'd0;
    logic [7:0]  wdata = 8'h00;
    logic        rd = 1'b0, wr = 1'b0, mem_io = 1'b0, dma_ack = 1'b0;
    logic [7:0]  rdata, irq_out;
    logic        WAIT, dma_req;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] mem_m [0:MEM_BYTES-1];
    logic [7:0] m_scratch = 8'h00, m_irq = 8'h00, m_len = 8'h00, m_rdata = 8'h00;
    logic [1:0] m_err = 2'b00;
    logic       m_busy = 1'b0;

    bus_responder #(.MEM_AW(MEM_AW), .MEM_WS(MEM_WS), .IO_WS(IO_WS)) dut (
        .clk(clk), .arst(arst), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .mem_io(mem_io), .dma_ack(dma_ack), .rdata(rdata), .WAIT(WAIT),
        .irq_out(irq_out), .dma_req(dma_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic io, input logic [21:0] a);
        if (!io) return (int'(a) < MEM_BYTES) ? mem_m[a[MEM_AW-1:0]] : 8'hFF;
        case (a[7:0])
            8'h00: return m_scratch;
            8'h01, 8'h02: return m_irq;
            8'h03: return {7'd0, m_busy};
            8'h04: return m_len;
            8'h05: return {6'd0, m_err};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(input logic io, input logic [21:0] a, input logic [7:0] d);
        if (!io) begin
            if (int'(a) < MEM_BYTES) mem_m[a[MEM_AW-1:0]] = d;
        end else begin
            case (a[7:0])
                8'h00: m_scratch = d;
                8'h01: m_irq = m_irq | d;
                8'h02: m_irq = m_irq & ~d;
                8'h03: if (d[0]) begin
                           if (m_busy) m_err[1] = 1'b1;
                           else m_busy = 1'b1;
                       end
                8'h04: m_len = d;
                8'h05: m_err = 2'b00;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_scratch = 8'h00; m_irq = 8'h00; m_len = 8'h00;
        m_rdata = 8'h00; m_err = 2'b00; m_busy = 1'b0;
    endtask

    // One bus cycle; address/data/space are scrambled after the start edge
    task automatic bus_cycle(input logic io, input logic [21:0] a, input logic [7:0] d,
                             input logic r, input logic w, output int waits, output logic [7:0] got);
        addr = a; wdata = d; mem_io = ~io; rd = r; wr = w;
        waits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            addr = 22'($urandom); wdata = 8'($urandom); mem_io = 1'($urandom);
            if (WAIT) waits++;
            else break;
        end
        got = rdata;
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic xact(input logic io, input logic [21:0] a, input logic [7:0] d,
                        input logic r, input logic w);
        int waits;
        logic [7:0] got;
        if (r) begin
            m_rdata = model_read(io, a);
            if (w) m_err[0] = 1'b1;
        end else if (w) begin
            model_write(io, a, d);
        end
        bus_cycle(io, a, d, r, w, waits, got);
        check("wait_cycles", waits, io ? IO_WS : MEM_WS);
        check("rdata", got, m_rdata);
        check("irq_out", irq_out, m_irq);
        check("dma_req", dma_req, m_busy);
    endtask

    task automatic dma_run(input logic [7:0] len, input int pre, input logic restart);
        int n;
        xact(1'b1, 22'h04, len, 1'b0, 1'b1);
        xact(1'b1, 22'h03, 8'h01, 1'b0, 1'b1);
        repeat (pre) begin
            @(posedge clk); #1;
            check("dma_req_pending", dma_req, 1'b1);
        end
        if (restart) begin
            xact(1'b1, 22'h03, 8'h01, 1'b0, 1'b1);
            xact(1'b1, 22'h05, 8'h00, 1'b1, 1'b0);
            xact(1'b1, 22'h03, 8'h00, 1'b1, 1'b0);
        end
        dma_ack = 1'b1;
        @(posedge clk); #1;
        check("dma_req_ack_edge", dma_req, 1'b1);
        n = 0;
        while (dma_req && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("dma_hold_edges", n, int'(len) + 1);
        m_busy = 1'b0;
        xact(1'b1, 22'h03, 8'h00, 1'b1, 1'b0);
        dma_ack = 1'b0;
        if (restart) xact(1'b1, 22'h05, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic [21:0] base, a;
        logic [7:0] d;
        int kind, s;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wait", WAIT, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_irq", irq_out, 8'h00);
        check("rst_dma_req", dma_req, 1'b0);
        arst = 1'b0;
        xact(1'b1, 22'h00, 8'h00, 1'b1, 1'b0);
        xact(1'b1, 22'h04, 8'h00, 1'b1, 1'b0);
        xact(1'b1, 22'h05, 8'h00, 1'b1, 1'b0);

        // Memory write then read-back with one wait state
        xact(1'b0, 22'h000123, 8'h5A, 1'b0, 1'b1);
        xact(1'b0, 22'h000123, 8'h00, 1'b1, 1'b0);

        // Interrupt set/clear and out-of-range memory read
        xact(1'b1, 22'h000001, 8'h81, 1'b0, 1'b1);
        xact(1'b1, 22'h000002, 8'h01, 1'b0, 1'b1);
        xact(1'b0, 22'h3FFFFF, 8'h00, 1'b1, 1'b0);
        xact(1'b0, 22'h3FFFFF, 8'hC3, 1'b0, 1'b1);

        // Simultaneous strobes act as a read and flag ERR bit0
        xact(1'b0, 22'h000010, 8'h33, 1'b0, 1'b1);
        xact(1'b0, 22'h000010, 8'hEE, 1'b1, 1'b1);
        xact(1'b0, 22'h000010, 8'h00, 1'b1, 1'b0);
        xact(1'b1, 22'h000005, 8'h00, 1'b1, 1'b0);
        xact(1'b1, 22'h000005, 8'h00, 1'b0, 1'b1);

        dma_run(8'd3, 5, 1'b1);
        dma_run(8'd0, 2, 1'b0);
        dma_run(8'($urandom_range(1, 20)), $urandom_range(0, 4), 1'b0);

        // Reset in the middle of a stalled write
        xact(1'b0, 22'h000020, 8'h11, 1'b0, 1'b1);
        addr = 22'h000020; wdata = 8'h77; mem_io = 1'b1; wr = 1'b1;
        @(posedge clk); #1;
        check("stall_wait", WAIT, 1'b1);
        #1 arst = 1'b1;
        #1;
        check("arst_wait_drop", WAIT, 1'b0);
        check("arst_rdata", rdata, 8'h00);
        check("arst_irq", irq_out, 8'h00);
        wr = 1'b0;
        #1 arst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        xact(1'b0, 22'h000020, 8'h00, 1'b1, 1'b0);
        xact(1'b1, 22'h000005, 8'h00, 1'b1, 1'b0);

        // Random traffic over a small RAM window and the I/O map
        base = 22'($urandom_range(0, MEM_BYTES - 16));
        for (int i = 0; i < 16; i++) xact(1'b0, base + 22'(i), 8'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 150; i++) begin
            dma_ack = 1'($urandom);
            kind = $urandom_range(0, 9);
            s = $urandom_range(0, 3);
            d = 8'($urandom);
            if (kind <= 5) begin
                a = base + 22'($urandom_range(0, 15));
            end else if (kind == 6) begin
                a = 22'($urandom_range(MEM_BYTES, 22'h3FFFFF));
            end else begin
                a = {14'($urandom), 8'($urandom_range(0, 8) == 8 ? $urandom_range(8, 255)
                                                                : $urandom_range(0, 7))};
                if (a[7:0] == 8'h03) d[0] = 1'b0;
            end
            xact(kind >= 7, a, d, s != 1, s == 1 || s == 2);
        end
        dma_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
